// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - opcodes, sequencer state encodings and command-record sizing
package gpu_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_DRAW  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_FENCE = 2'd3
    } gpu_op_t;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETUP      = 3'd1;
    localparam logic [2:0] ST_STROBE     = 3'd2;
    localparam logic [2:0] ST_WAIT_START = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd4;
    localparam logic [2:0] ST_FENCE      = 3'd5;

    // op + address + three 16-bit source fields + clear color + screen rectangle
    function automatic int cmd_rec_bits(input int w, input int h);
        return 2 + 32 + 3 * 16 + 16 + 2 * w + 2 * h;
    endfunction

endpackage

// File: rtl/gpu_cmd_sequencer_if.sv
// rtl/gpu_cmd_sequencer_if.sv - CPU-side command bus into the GPU command sequencer
interface gpu_cmd_sequencer_if
    import gpu_pkg::*;
#(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240
);
    localparam int W = $clog2(FB_WIDTH) + 2;
    localparam int H = $clog2(FB_HEIGHT) + 2;

    logic         cmd_valid;
    logic         cmd_ready;
    gpu_op_t      cmd_op;
    logic [31:0]  cmd_address;
    logic [15:0]  cmd_address_x;
    logic [15:0]  cmd_address_y;
    logic [15:0]  cmd_image_width;
    logic [W-1:0] cmd_width;
    logic [W-1:0] cmd_x;
    logic [H-1:0] cmd_height;
    logic [H-1:0] cmd_y;
    logic [15:0]  cmd_clear_color;

    modport master (
        output cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
               cmd_image_width, cmd_width, cmd_x, cmd_height, cmd_y, cmd_clear_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_address, cmd_address_x, cmd_address_y,
               cmd_image_width, cmd_width, cmd_x, cmd_height, cmd_y, cmd_clear_color,
        output cmd_ready
    );

endinterface

// File: rtl/gpu_cmd_fifo.sv
// rtl/gpu_cmd_fifo.sv - synchronous command FIFO with registered occupancy count
module gpu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset: emptiness is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// rtl/gpu_cmd_sequencer.sv - queues draw/clear/fence commands and replays them on the GPU strobe/busy handshake
module gpu_cmd_sequencer
    import gpu_pkg::*;
#(
    parameter int  FB_WIDTH      = 400,
    parameter int  FB_HEIGHT     = 240,
    parameter int  DEPTH         = 4,
    parameter int  START_TIMEOUT = 8,
    localparam int W             = $clog2(FB_WIDTH) + 2,
    localparam int H             = $clog2(FB_HEIGHT) + 2,
    localparam int QW            = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    gpu_cmd_sequencer_if.slave  cmd,
    output logic [31:0]         gpu_address,
    output logic [15:0]         gpu_address_x,
    output logic [15:0]         gpu_address_y,
    output logic [15:0]         gpu_image_width,
    output logic [W-1:0]        gpu_width,
    output logic [W-1:0]        gpu_x,
    output logic [H-1:0]        gpu_height,
    output logic [H-1:0]        gpu_y,
    output logic [15:0]         gpu_clear_color,
    output logic                gpu_draw,
    output logic                gpu_clear,
    input  logic                gpu_busy,
    input  logic                vblank,
    output logic [QW-1:0]       queue_count,
    output logic                idle,
    output logic                error,
    input  logic                error_clear
);
    typedef struct packed {
        gpu_op_t      op;
        logic [31:0]  address;
        logic [15:0]  address_x;
        logic [15:0]  address_y;
        logic [15:0]  image_width;
        logic [W-1:0] width;
        logic [W-1:0] x;
        logic [H-1:0] height;
        logic [H-1:0] y;
        logic [15:0]  clear_color;
    } cmd_rec_t;

    localparam int              REC_W    = cmd_rec_bits(W, H);
    localparam int              TW       = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(START_TIMEOUT - 1);

    cmd_rec_t         in_rec;
    cmd_rec_t         head;
    logic [REC_W-1:0] head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [QW-1:0]    count;
    logic [2:0]       state;
    gpu_op_t          cur_op;
    logic [TW-1:0]    tmo_cnt;
    logic             vblank_q;

    assign in_rec = {cmd.cmd_op, cmd.cmd_address, cmd.cmd_address_x, cmd.cmd_address_y,
                     cmd.cmd_image_width, cmd.cmd_width, cmd.cmd_x, cmd.cmd_height,
                     cmd.cmd_y, cmd.cmd_clear_color};
    assign head   = cmd_rec_t'(head_bits);

    // Ready follows the registered count only, so a full FIFO refuses even when a pop is due.
    assign cmd.cmd_ready = ~reset & ~fifo_full;
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign pop           = (state == ST_IDLE) & ~fifo_empty;
    assign queue_count   = count;
    assign idle          = ~reset & (state == ST_IDLE) & (count == '0);

    gpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (in_rec),
        .pop   (pop),
        .rdata (head_bits),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            cur_op          <= OP_NOP;
            tmo_cnt         <= '0;
            vblank_q        <= 1'b0;
            error           <= 1'b0;
            gpu_draw        <= 1'b0;
            gpu_clear       <= 1'b0;
            gpu_address     <= '0;
            gpu_address_x   <= '0;
            gpu_address_y   <= '0;
            gpu_image_width <= '0;
            gpu_width       <= '0;
            gpu_x           <= '0;
            gpu_height      <= '0;
            gpu_y           <= '0;
            gpu_clear_color <= '0;
        end else begin
            vblank_q  <= vblank;
            gpu_draw  <= 1'b0;
            gpu_clear <= 1'b0;
            if (error_clear) begin
                error <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    // NOPs are dropped here so they never disturb the parameters on the GPU.
                    if (pop && head.op != OP_NOP) begin
                        cur_op          <= head.op;
                        gpu_address     <= head.address;
                        gpu_address_x   <= head.address_x;
                        gpu_address_y   <= head.address_y;
                        gpu_image_width <= head.image_width;
                        gpu_width       <= head.width;
                        gpu_x           <= head.x;
                        gpu_height      <= head.height;
                        gpu_y           <= head.y;
                        gpu_clear_color <= head.clear_color;
                        state           <= (head.op == OP_FENCE) ? ST_FENCE : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    gpu_draw  <= (cur_op == OP_DRAW);
                    gpu_clear <= (cur_op == OP_CLEAR);
                    state     <= ST_STROBE;
                end
                ST_STROBE: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (gpu_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!gpu_busy) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FENCE: begin
                    if (vblank && !vblank_q) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// tb/tb_gpu_cmd_sequencer.sv - randomized bench for gpu_cmd_sequencer against a command-timeline model
module tb_gpu_cmd_sequencer;
    import gpu_pkg::*;

    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;
    localparam int DEPTH     = 4;
    localparam int T         = 8;
    localparam int W         = $clog2(FB_WIDTH) + 2;
    localparam int H         = $clog2(FB_HEIGHT) + 2;
    localparam int FW        = 32 + 48 + 16 + 2 * W + 2 * H;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   gpu_busy, vblank, error_clear;
    logic                   gpu_draw, gpu_clear, idle, error;
    logic [31:0]            gpu_address;
    logic [15:0]            gpu_address_x, gpu_address_y, gpu_image_width, gpu_clear_color;
    logic [W-1:0]           gpu_width, gpu_x;
    logic [H-1:0]           gpu_height, gpu_y;
    logic [$clog2(DEPTH):0] queue_count;

    always #5 clk = ~clk;

    gpu_cmd_sequencer_if #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) cmd_if ();

    gpu_cmd_sequencer #(
        .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .DEPTH(DEPTH), .START_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset), .cmd(cmd_if),
        .gpu_address(gpu_address), .gpu_address_x(gpu_address_x), .gpu_address_y(gpu_address_y),
        .gpu_image_width(gpu_image_width), .gpu_width(gpu_width), .gpu_x(gpu_x),
        .gpu_height(gpu_height), .gpu_y(gpu_y), .gpu_clear_color(gpu_clear_color),
        .gpu_draw(gpu_draw), .gpu_clear(gpu_clear), .gpu_busy(gpu_busy), .vblank(vblank),
        .queue_count(queue_count), .idle(idle), .error(error), .error_clear(error_clear)
    );

    // One accepted command and the edges at which the model says things happen to it.
    typedef struct {
        int            op;
        logic [FW-1:0] f;
        int            push, pop, ret, te, bs, be;
    } mcmd_t;

    mcmd_t         mq[$];
    logic [FW-1:0] hold_f;
    int            free_at, cyc, n_checks, n_errors;
    bit            err_m, hit;

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic bit vb(input int c);
        return (c % 37) < 6;
    endfunction

    function automatic int cnt_after(input int c);
        int n = 0;
        foreach (mq[i]) begin
            if (mq[i].push <= c) n++;
            if (mq[i].pop <= c) n--;
        end
        return n;
    endfunction

    function automatic bit busy_at(input int c);
        foreach (mq[i]) if (mq[i].bs <= c && c <= mq[i].be) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_wait_done(input int c);
        foreach (mq[i]) if (mq[i].bs <= mq[i].be && mq[i].bs <= c && c < mq[i].ret) return 1'b1;
        return 1'b0;
    endfunction

    // Pop one edge after push or once the previous command has released the engine.
    task automatic model_push(input int c, input int op, input logic [FW-1:0] f,
                              input bit never, input int d, input int l);
        mcmd_t m;
        int    k, e;
        m.op = op; m.f = f; m.push = c;
        m.pop = (c + 1 > free_at) ? c + 1 : free_at;
        m.te = -1; m.bs = 0; m.be = -1;
        k = m.pop + 2;
        if (op == 0) begin
            m.ret = m.pop;
        end else if (op == 3) begin
            e = m.pop + 1;
            while (!(vb(e) && !vb(e - 1))) e++;
            m.ret = e;
        end else if (never) begin
            m.te = k + T;
            m.ret = m.te;
        end else begin
            m.bs = k + d + 1;
            m.be = k + d + l;
            m.ret = m.be + 1;
        end
        free_at = m.ret + 1;
        mq.push_back(m);
    endtask

    task automatic check_outputs(input int c);
        int            n;
        bit            e_draw, e_clear, active;
        logic [FW-1:0] e_f;
        n = cnt_after(c); e_draw = 0; e_clear = 0; active = 0; e_f = hold_f;
        foreach (mq[i]) begin
            if (mq[i].op == 1 && mq[i].pop + 1 == c) e_draw = 1;
            if (mq[i].op == 2 && mq[i].pop + 1 == c) e_clear = 1;
            if (mq[i].op != 0 && mq[i].pop <= c && c < mq[i].ret) active = 1;
            if (mq[i].op != 0 && mq[i].pop <= c) e_f = mq[i].f;
        end
        check("cmd_ready", cmd_if.cmd_ready, n < DEPTH);
        check("queue_count", queue_count, n);
        check("gpu_draw", gpu_draw, e_draw);
        check("gpu_clear", gpu_clear, e_clear);
        check("idle", idle, !active && n == 0);
        check("error", error, err_m);
        check("gpu_fields", {gpu_address, gpu_address_x, gpu_address_y, gpu_image_width,
              gpu_width, gpu_x, gpu_height, gpu_y, gpu_clear_color}, e_f);
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready", cmd_if.cmd_ready, 1'b0);
        check("rst_queue_count", queue_count, 0);
        check("rst_strobes", {gpu_draw, gpu_clear}, 2'b00);
        check("rst_idle", idle, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_fields", {gpu_address, gpu_address_x, gpu_address_y, gpu_image_width,
              gpu_width, gpu_x, gpu_height, gpu_y, gpu_clear_color}, 0);
    endtask

    task automatic do_reset(input int hold);
        cmd_if.cmd_valid = 1'b0; gpu_busy = 1'b0; error_clear = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals();
        repeat (hold) @(posedge clk);
        #1;
        cyc += hold;
        reset = 1'b0;
        mq.delete(); free_at = 0; err_m = 0; hold_f = '0;
        #1;
    endtask

    task automatic step(input bit allow_push);
        bit            v, rdy, never, ec;
        int            op, r, d, l;
        logic [31:0]   addr;
        logic [15:0]   ax, ay, iw, col;
        logic [W-1:0]  wd, xx;
        logic [H-1:0]  ht, yy;
        logic [FW-1:0] f;
        check_outputs(cyc);
        rdy = cnt_after(cyc) < DEPTH;
        v = allow_push && ($urandom_range(0, 99) < 55);
        r = $urandom_range(0, 99);
        op = (r < 10) ? 0 : (r < 20) ? 3 : (r < 60) ? 1 : 2;
        addr = $urandom(); ax = 16'($urandom()); ay = 16'($urandom()); iw = 16'($urandom());
        col = 16'($urandom()); wd = W'($urandom()); xx = W'($urandom());
        ht = H'($urandom()); yy = H'($urandom());
        f = {addr, ax, ay, iw, wd, xx, ht, yy, col};
        never = $urandom_range(0, 99) < 20;
        d = $urandom_range(0, T - 1);
        l = $urandom_range(1, 12);
        ec = $urandom_range(0, 99) < 4;
        cmd_if.cmd_valid = v; cmd_if.cmd_op = gpu_op_t'(2'(op));
        cmd_if.cmd_address = addr; cmd_if.cmd_address_x = ax; cmd_if.cmd_address_y = ay;
        cmd_if.cmd_image_width = iw; cmd_if.cmd_width = wd; cmd_if.cmd_x = xx;
        cmd_if.cmd_height = ht; cmd_if.cmd_y = yy; cmd_if.cmd_clear_color = col;
        gpu_busy = busy_at(cyc + 1);
        vblank = vb(cyc + 1);
        error_clear = ec;
        @(posedge clk);
        #1;
        cyc++;
        if (v && rdy) model_push(cyc, op, f, never, d, l);
        begin
            bit to = 0;
            foreach (mq[i]) if (mq[i].te == cyc) to = 1;
            if (to) err_m = 1;
            else if (ec) err_m = 0;
        end
        while (mq.size() > 0 && mq[0].ret + 2 < cyc && mq[0].pop < cyc) begin
            if (mq[0].op != 0) hold_f = mq[0].f;
            void'(mq.pop_front());
        end
    endtask

    initial begin
        reset = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = OP_NOP; cmd_if.cmd_address = '0;
        cmd_if.cmd_address_x = '0; cmd_if.cmd_address_y = '0; cmd_if.cmd_image_width = '0;
        cmd_if.cmd_width = '0; cmd_if.cmd_x = '0; cmd_if.cmd_height = '0; cmd_if.cmd_y = '0;
        cmd_if.cmd_clear_color = '0;
        gpu_busy = 1'b0; vblank = 1'b0; error_clear = 1'b0;
        n_checks = 0; n_errors = 0; cyc = 0; free_at = 0; err_m = 0; hold_f = '0; hit = 0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 1600; i++) begin
            if (!hit && cyc > 300 && cnt_after(cyc) >= 2 && in_wait_done(cyc)) begin
                hit = 1;
                do_reset(3);
            end
            step(1'b1);
        end
        for (int i = 0; i < 200; i++) step(1'b0);
        check("reset_in_wait_done_hit", hit, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
